// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and op-class helpers for the sequential ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_MULLO = 4'd5,
      OP_MULHI = 4'd6,
      OP_DIV   = 4'd7,
      OP_REM   = 4'd8
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ITER,
      S_FIX,
      S_DONE
   } state_e;

   function automatic logic is_mul(logic [3:0] opc);
      return (opc == OP_MULLO) || (opc == OP_MULHI);
   endfunction

   function automatic logic is_div(logic [3:0] opc);
      return (opc == OP_DIV) || (opc == OP_REM);
   endfunction

   function automatic logic is_iter(logic [3:0] opc);
      return is_mul(opc) || is_div(opc);
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Unsigned iterative core: shift-add multiply or restoring divide, one bit per cycle.
// done flags the cycle whose closing edge performs the final step.
module seq_muldiv #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   ma,
   input  logic [WIDTH-1:0]   mb,
   output logic [2*WIDTH-1:0] acc,
   output logic               done
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   mc;
   logic [CW-1:0]      cnt;
   logic               div_q;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     rem_diff;
   logic [2*WIDTH-1:0] acc_nxt;

   // Multiply: acc = {partial, multiplier}, shifted right each step.
   // Divide:   acc = {remainder, dividend/quotient}, shifted left each step.
   always_comb begin
      add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mc : '0)};
      rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, mc};
      if (div_q) begin
         if (!rem_diff[WIDTH])
            acc_nxt = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_nxt = {add_sum, acc[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         mc    <= '0;
         cnt   <= '0;
         div_q <= 1'b0;
      end else if (load) begin
         acc   <= {{WIDTH{1'b0}}, ma};
         mc    <= mb;
         cnt   <= CW'(WIDTH);
         div_q <= is_div;
      end else if (cnt != '0) begin
         acc   <= acc_nxt;
         cnt   <= cnt - 1'b1;
      end
   end

   assign done = (cnt == CW'(1));

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: handshake FSM, single-cycle ops, sign handling and flags
// around the shared iterative multiply/divide core.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic             signed_en,
   input  logic             carry_en,
   input  logic             carry_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             div_zero
);

   typedef struct packed {
      logic [3:0]       op;
      logic             sgn;
      logic             cen;
      logic             cin;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } req_t;

   state_e             state, state_nxt;
   req_t               req;
   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   ma, mb;
   logic               md_load, md_done;
   logic [2*WIDTH-1:0] md_acc;
   logic [WIDTH:0]     sum_w, diff_w;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s;
   logic               mul_ovf, div_ovf;
   logic [WIDTH-1:0]   res_n;
   logic               co_n, ov_n, dz_n, upd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = is_iter(req.op) ? S_ITER : S_DONE;
         S_ITER:  if (md_done) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         req <= '0;
      else if (state == S_IDLE && start)
         req <= {op, signed_en, carry_en, carry_in, a, b};
   end

   // The core works on magnitudes; signs are reapplied in FIX.
   assign neg_a   = req.sgn & req.a[WIDTH-1];
   assign neg_b   = req.sgn & req.b[WIDTH-1];
   assign ma      = neg_a ? -req.a : req.a;
   assign mb      = neg_b ? -req.b : req.b;
   assign md_load = (state == S_LOAD) && is_iter(req.op);

   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (md_load),
      .is_div (is_div(req.op)),
      .ma     (ma),
      .mb     (mb),
      .acc    (md_acc),
      .done   (md_done)
   );

   always_comb begin
      sum_w   = {1'b0, req.a} + {1'b0, req.b} + (WIDTH+1)'(req.cen & req.cin);
      diff_w  = {1'b0, req.a} - {1'b0, req.b} - (WIDTH+1)'(req.cen & ~req.cin);
      prod_s  = (neg_a ^ neg_b) ? -md_acc : md_acc;
      quo_s   = (neg_a ^ neg_b) ? -md_acc[WIDTH-1:0] : md_acc[WIDTH-1:0];
      rem_s   = neg_a ? -md_acc[2*WIDTH-1:WIDTH] : md_acc[2*WIDTH-1:WIDTH];
      mul_ovf = req.sgn ? (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}})
                        : (prod_s[2*WIDTH-1:WIDTH] != '0);
      // Most-negative / -1: the magnitude quotient already reads back as MIN.
      div_ovf = req.sgn && (req.a == {1'b1, {(WIDTH-1){1'b0}}}) && (&req.b);
   end

   always_comb begin
      res_n = '0;
      co_n  = 1'b0;
      ov_n  = 1'b0;
      dz_n  = 1'b0;
      case (req.op)
         OP_ADD: begin
            res_n = sum_w[WIDTH-1:0];
            co_n  = sum_w[WIDTH];
            ov_n  = (req.a[WIDTH-1] == req.b[WIDTH-1]) && (sum_w[WIDTH-1] != req.a[WIDTH-1]);
         end
         OP_SUB: begin
            res_n = diff_w[WIDTH-1:0];
            co_n  = ~diff_w[WIDTH];
            ov_n  = (req.a[WIDTH-1] != req.b[WIDTH-1]) && (diff_w[WIDTH-1] != req.a[WIDTH-1]);
         end
         OP_AND:   res_n = req.a & req.b;
         OP_OR:    res_n = req.a | req.b;
         OP_XOR:   res_n = req.a ^ req.b;
         OP_MULLO: begin
            res_n = prod_s[WIDTH-1:0];
            ov_n  = mul_ovf;
         end
         OP_MULHI: begin
            res_n = prod_s[2*WIDTH-1:WIDTH];
            ov_n  = mul_ovf;
         end
         OP_DIV: begin
            if (req.b == '0) begin
               res_n = '1;
               dz_n  = 1'b1;
            end else begin
               res_n = quo_s;
               ov_n  = div_ovf;
            end
         end
         OP_REM: begin
            if (req.b == '0) begin
               res_n = req.a;
               dz_n  = 1'b1;
            end else begin
               res_n = rem_s;
            end
         end
         default: ;
      endcase
   end

   // Outputs move only on the edge that enters DONE.
   assign upd = ((state == S_LOAD) && !is_iter(req.op)) || (state == S_FIX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         div_zero  <= 1'b0;
      end else if (upd) begin
         result    <= res_n;
         carry_out <= co_n;
         overflow  <= ov_n;
         zero      <= (res_n == '0);
         div_zero  <= dz_n;
      end
   end

endmodule
